vec_sum_sequencer: RTL
======================

VEC_SUM_SEQUENCER -- requirements
Module: vec_sum_sequencer

Interface
REQ-001 Parameter: LEN_W, 8, width of the vector-length field and the element counter.
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  one-cycle pulse requesting a new vector sum; sampled only in IDLE.
REQ-005 Port: len  input  LEN_W  element count; captured when start is accepted.
REQ-006 Port: busy  output  1  high in ACCUM and DONE.
REQ-007 Port: in_valid  input  1  element available.
REQ-008 Port: in_data  input  39  element word: [38:30] 9-bit exponent, [29:0] 30-bit mantissa (fp_adder format).
REQ-009 Port: in_ready  output  1  sequencer accepts an element this cycle.
REQ-010 Port: out_valid  output  1  final sum available.
REQ-011 Port: out_data  output  39  final sum, same format as in_data.
REQ-012 Port: out_ready  input  1  consumer takes the sum.

Function
REQ-013 The block SHALL implement the states IDLE, ACCUM and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture len, clear acc to 39'b0 and cnt to 0, then move to ACCUM, or to DONE when len=0.
REQ-015 in_ready SHALL equal 1 only in ACCUM; an element transfers on in_valid & in_ready.
REQ-016 On each transfer, acc SHALL load fp_adder(acc, in_data) at the next edge, and cnt SHALL increment (one element per cycle, no bubbles).
REQ-017 On the transfer where cnt = len-1, the block SHALL move to DONE on the same edge that updates acc.
REQ-018 In DONE, out_valid SHALL be 1 and out_data SHALL equal acc, held stable until out_ready=1.
REQ-019 On out_valid & out_ready, the block SHALL return to IDLE at the next edge, and out_valid SHALL fall.
REQ-020 Latency SHALL be N+1 cycles from start to out_valid for N back-to-back elements; len=0 SHALL give out_valid one cycle after start with out_data=39'b0.
REQ-021 The block SHALL ignore start outside IDLE.
REQ-022 The block SHALL ignore in_valid outside ACCUM, and in_data SHALL NOT affect acc there.
REQ-023 In ACCUM, in_valid=0 SHALL stall with acc and cnt held; there is no timeout.
REQ-024 len = 2^LEN_W-1 SHALL complete without counter wrap.
REQ-025 out_data SHALL be driven from the acc register only, not combinationally from in_data.

Reset
REQ-026 When rst_n=0 at a clock edge, the block SHALL force state IDLE, acc=0, cnt=0, captured len=0, busy=0, in_ready=0 and out_valid=0.
REQ-027 Reset asserted in ACCUM or DONE SHALL abort the operation with no out_valid pulse, and any pending sum is lost.
REQ-028 After rst_n returns to 1, the block SHALL accept start on the first following edge.

Structure
REQ-029 A shared package SHALL hold FP_W=39, EXP_W=9, MAN_W=30, FP_ZERO, and the state enum.
REQ-030 The block SHALL instantiate exactly one fp_adder sub-module (a_original=acc, b_original=in_data, sum feeding acc), shared across all elements.
REQ-031 The block SHALL use no other arithmetic; cnt compare is the only datapath besides fp_adder.

Verification
REQ-032 len=1, A=39'b000000000_1101 followed by 26 zeros -> out_valid after 2 cycles, out_data == fp_adder(0,A).
REQ-033 len=2, elements A and B=39'b000000000_1110 followed by 26 zeros, back-to-back -> out_data == fp_adder(fp_adder(0,A),B), out_valid at cycle 3.
REQ-034 len=0 start -> out_valid next cycle, out_data=0, in_ready never high.
REQ-035 len=4 with in_valid gaps of 3 cycles and out_ready held low 5 cycles -> sum matches the model, out_data stable while stalled, start pulses during busy ignored.
REQ-036 rst_n=0 asserted after 2 of 4 elements -> all outputs 0 next cycle; a new len=1 run then yields the correct sum.
REQ-037 len=255 with random elements -> exactly 255 transfers, one out_valid, result equals the sequential fp_adder model.

Source files
------------

// File: rtl/vec_sum_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | vec_sum_sequencer_pkg: shared widths, zero word and FSM states       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package vec_sum_sequencer_pkg;

  localparam int FP_W  = 39;
  localparam int EXP_W = 9;
  localparam int MAN_W = 30;

  localparam logic [FP_W-1:0] FP_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/vec_sum_sequencer_fp_adder.sv
// +----------------------------------------------------------------------+
// | fp_adder: unsigned exponent/mantissa adder, aligns to larger exponent|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fp_adder
  import vec_sum_sequencer_pkg::*;
(
  input  logic [FP_W-1:0] a_original,
  input  logic [FP_W-1:0] b_original,
  output logic [FP_W-1:0] sum
);

  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_SHMAX = EXP_W'(MAN_W);

  logic [EXP_W-1:0] w_exp_a;
  logic [EXP_W-1:0] w_exp_b;
  logic [EXP_W-1:0] w_exp_big;
  logic [EXP_W-1:0] w_exp_diff;
  logic [MAN_W-1:0] w_man_a;
  logic [MAN_W-1:0] w_man_b;
  logic [MAN_W-1:0] w_man_big;
  logic [MAN_W-1:0] w_man_small;
  logic [MAN_W-1:0] w_man_shift;
  logic [MAN_W:0]   w_man_sum;

  always_comb begin
    w_exp_a = a_original[FP_W-1:MAN_W];
    w_exp_b = b_original[FP_W-1:MAN_W];
    w_man_a = a_original[MAN_W-1:0];
    w_man_b = b_original[MAN_W-1:0];

    if (w_exp_a >= w_exp_b) begin
      w_exp_big   = w_exp_a;
      w_man_big   = w_man_a;
      w_man_small = w_man_b;
      w_exp_diff  = w_exp_a - w_exp_b;
    end else begin
      w_exp_big   = w_exp_b;
      w_man_big   = w_man_b;
      w_man_small = w_man_a;
      w_exp_diff  = w_exp_b - w_exp_a;
    end

    w_man_shift = (w_exp_diff >= EXP_SHMAX) ? '0 : (w_man_small >> w_exp_diff);
    w_man_sum   = {1'b0, w_man_big} + {1'b0, w_man_shift};

    // Mantissa carry renormalises by one; at the top exponent it saturates.
    if (!w_man_sum[MAN_W]) begin
      sum = {w_exp_big, w_man_sum[MAN_W-1:0]};
    end else if (&w_exp_big) begin
      sum = {w_exp_big, {MAN_W{1'b1}}};
    end else begin
      sum = {w_exp_big + EXP_ONE, w_man_sum[MAN_W:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/vec_sum_sequencer.sv
// +----------------------------------------------------------------------+
// | vec_sum_sequencer: streams len elements through one fp_adder into acc|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vec_sum_sequencer
  import vec_sum_sequencer_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  input  logic [FP_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [FP_W-1:0]  out_data,
  input  logic             out_ready
);

  state_e           state_q, state_d;
  logic [FP_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [FP_W-1:0]  w_sum;
  logic [LEN_W:0]   w_cnt_inc;
  logic             w_last;

  fp_adder u_fp_adder (
    .a_original (acc_q),
    .b_original (in_data),
    .sum        (w_sum)
  );

  // One extra bit keeps len = 2^LEN_W-1 from wrapping on the final element.
  assign w_cnt_inc = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};
  assign w_last    = (w_cnt_inc == {1'b0, len_q});

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = FP_ZERO;
          cnt_d   = '0;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = w_sum;
          cnt_d = w_cnt_inc[LEN_W-1:0];
          if (w_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= FP_ZERO;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;

endmodule

`default_nettype wire
